// File: rtl/mesh_pkt_injector.sv
// mesh_pkt_injector: multi-channel mesh packet source with per-channel FIFO, pndng/popin delivery and status
module mesh_pkt_injector #(
    parameter int          ROWS       = 4,
    parameter int          COLUMS     = 4,
    parameter int          NCH        = 16,
    parameter int          pckg_sz    = 40,
    parameter int          fifo_depth = 4,
    parameter logic [7:0]  bdcst      = 8'hFF,
    parameter int          CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NCH-1:0]                 wr_en,
    input  logic [NCH*4-1:0]               wr_row,
    input  logic [NCH*4-1:0]               wr_colum,
    input  logic [NCH-1:0]                 wr_mode,
    input  logic [NCH-1:0]                 wr_bcst,
    input  logic [NCH*(pckg_sz-17)-1:0]    wr_payload,
    output logic [NCH*pckg_sz-1:0]         data_out_i_in,
    output logic [NCH-1:0]                 pndng_i_in,
    input  logic [NCH-1:0]                 popin,
    output logic [NCH-1:0]                 full,
    output logic [NCH-1:0]                 ovf,
    output logic [NCH-1:0]                 dst_err,
    output logic [NCH*CNT_W-1:0]           sent_cnt
);
    localparam int PW = pckg_sz - 17;
    localparam int AW = $clog2(fifo_depth);
    localparam int CW = $clog2(fifo_depth + 1);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [pckg_sz-1:0] mem_q [fifo_depth];
        logic [pckg_sz-1:0] last_q, pkt;
        logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
        logic [CW-1:0]      cnt_q, cnt_d;
        logic [CNT_W-1:0]   sent_q;
        logic               ovf_q, dst_q, legal, push, pop, is_full, drop;
        logic [3:0]         row, col;

        // Header assembly, destination legality and push/pop qualification
        always_comb begin
            row     = wr_row[c*4 +: 4];
            col     = wr_colum[c*4 +: 4];
            pkt     = {wr_bcst[c] ? bdcst : 8'h00, row, col, wr_mode[c], wr_payload[c*PW +: PW]};
            legal   = wr_bcst[c] || (int'(row) <= ROWS + 1 && int'(col) <= COLUMS + 1);
            is_full = cnt_q == CW'(fifo_depth);
            pop     = popin[c] && cnt_q != '0;
            push    = wr_en[c] && legal && (!is_full || popin[c]);
            drop    = wr_en[c] && legal && is_full && !popin[c];
            cnt_d   = (push && !pop) ? cnt_q + 1'b1 : (!push && pop) ? cnt_q - 1'b1 : cnt_q;
        end

        // Pointers, occupancy, sticky overflow, error pulse, sent counter and held head
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                sent_q   <= '0;
                ovf_q    <= 1'b0;
                dst_q    <= 1'b0;
                last_q   <= '0;
            end else begin
                wr_ptr_q <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
                rd_ptr_q <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
                cnt_q    <= cnt_d;
                sent_q   <= pop ? sent_q + 1'b1 : sent_q;
                ovf_q    <= ovf_q || drop;
                dst_q    <= wr_en[c] && !legal;
                last_q   <= cnt_q != '0 ? mem_q[rd_ptr_q] : last_q;
            end
        end

        // Packet storage; contents are only visible while the channel is pending
        always_ff @(posedge clk) begin
            if (push) mem_q[wr_ptr_q] <= pkt;
        end

        assign pndng_i_in[c]                      = cnt_q != '0;
        assign full[c]                            = is_full;
        assign ovf[c]                             = ovf_q;
        assign dst_err[c]                         = dst_q;
        assign sent_cnt[c*CNT_W +: CNT_W]         = sent_q;
        assign data_out_i_in[c*pckg_sz +: pckg_sz] = cnt_q != '0 ? mem_q[rd_ptr_q] : last_q;
    end
endmodule

// File: doc/mesh_pkt_injector.md
Name: mesh_pkt_injector

Overview:
- Parametrised multi-channel packet source for the mesh_gnrtr external terminals. It replaces hand-driven data_out_i_in/pndng_i_in stimulus.
- Each channel accepts local write requests and assembles the 40-bit mesh header {Nxtjp,row,colum,mode,payload}.
- Each channel queues packets in its own FIFO and presents the queue head to the router with the pndng/popin handshake.
- Adds per-channel overflow/illegal-destination flagging and per-channel sent-packet counters.

Parameters:
- ROWS, 4, mesh rows; legal terminal row coordinates are 0..ROWS+1.
- COLUMS, 4, mesh columns; legal terminal column coordinates are 0..COLUMS+1.
- NCH, 16, number of channels; nominally ROWS*2+COLUMS*2.
- pckg_sz, 40, packet width in bits; must be >= 18.
- fifo_depth, 4, entries per channel FIFO; power of two, >= 2.
- bdcst, 8'hFF, Nxtjp value that marks a broadcast packet.
- CNT_W, 16, width of each sent-packet counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  NCH  per-channel write request; each bit is a one-cycle push.
- wr_row  in  NCH*4  destination row, 4 bits per channel.
- wr_colum  in  NCH*4  destination column, 4 bits per channel.
- wr_mode  in  NCH  routing mode bit per channel.
- wr_bcst  in  NCH  broadcast request per channel.
- wr_payload  in  NCH*(pckg_sz-17)  payload per channel.
- data_out_i_in  out  NCH*pckg_sz  head packet per channel, toward the router.
- pndng_i_in  out  NCH  channel FIFO non-empty.
- popin  in  NCH  router consumes the head packet of the channel.
- full  out  NCH  channel FIFO holds fifo_depth entries.
- ovf  out  NCH  sticky: a push was dropped because the FIFO was full.
- dst_err  out  NCH  one-cycle pulse: a push was rejected for an illegal destination.
- sent_cnt  out  NCH*CNT_W  packets popped per channel.

Behaviour:
- Reset (asynchronous assert, synchronous release): all FIFOs empty and pointers 0; pndng_i_in=0, full=0, ovf=0, dst_err=0, sent_cnt=0, data_out_i_in=0.
- Packet assembly for channel i, MSB to LSB:
  - [pckg_sz-1:pckg_sz-8] = bdcst if wr_bcst[i], else 8'h00.
  - [pckg_sz-9:pckg_sz-12] = wr_row.
  - [pckg_sz-13:pckg_sz-16] = wr_colum.
  - [pckg_sz-17] = wr_mode.
  - [pckg_sz-18:0] = wr_payload.
- Destination check, skipped when wr_bcst[i]=1: legal when wr_row<=ROWS+1 and wr_colum<=COLUMS+1.
  - An illegal push is discarded and dst_err[i] pulses for 1 cycle.
  - An illegal push does not set ovf.
- Push: wr_en[i] with a legal destination and either not full, or full with a simultaneous popin[i], writes at wr_ptr and increments the count.
  - pndng_i_in[i] rises in the cycle after the push edge, so push-to-visible latency is 1 clock.
- Overflow: wr_en[i] while full without popin[i] drops the packet and sets ovf[i].
  - ovf[i] clears only on reset.
  - FIFO contents are unchanged.
- Pop: popin[i] while pndng_i_in[i]=1 advances rd_ptr, decrements the count and increments sent_cnt[i].
  - The next head appears on data_out_i_in the following cycle.
  - popin[i] while empty is ignored: no counter change, no error.
- Simultaneous push and pop on a non-empty FIFO: count unchanged, both pointers advance.
  - Simultaneous push and pop on an empty FIFO: the push completes and the pop is ignored.
- data_out_i_in[i] is driven from storage at rd_ptr whenever pndng_i_in[i]=1; it holds its last value when empty.
  - The router samples it only while pndng_i_in is high.
- Pointers wrap modulo fifo_depth; the count is fifo_depth+1 states wide. full[i] = (count==fifo_depth).
- sent_cnt wraps modulo 2^CNT_W without a flag.
- Channels are fully independent; there is no cross-channel arbitration.
- Reset asserted mid-operation flushes all queued packets immediately. pndng_i_in drops asynchronously.

Test Plan:
- Single packet, ch0: row=0, colum=2, mode=1, payload=5'b10101, bcst=0 -> pndng_i_in[0]=1 one cycle later; data_out_i_in[0]={8'h00,4'd0,4'd2,1'b1,23'b10101}. One popin[0] -> pndng_i_in[0]=0, sent_cnt[0]=1.
- Fill/overflow, ch3, fifo_depth=4: 5 back-to-back pushes, payloads 1..5 -> full[3]=1 after the 4th; 5th dropped; ovf[3]=1. Four pops return payloads 1,2,3,4 in order; sent_cnt[3]=4.
- Full plus simultaneous push/pop, ch1 full with payloads 1..4: push payload 9 together with popin -> no ovf; full stays 1. Subsequent heads are 2,3,4,9.
- Destination check, ch2: push row=6, colum=1 -> dst_err[2] pulses 1 cycle; pndng_i_in[2] stays 0. Same push with bcst=1 -> accepted, Nxtjp field=8'hFF.
- Empty pop and counter wrap, CNT_W=2: popin[5] while empty -> no change. 5 push/pop pairs -> sent_cnt[5]=1.
- Reset mid-stream: ch0..ch3 each holding 2 packets, assert reset for 3 cycles -> all pndng_i_in=0, full=0, ovf=0, sent_cnt=0. First push after release is delivered correctly.
